pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage RISC-V core.
- Arbitrates the single memory-controller port between instruction fetch (IF) and load/store (MEM).
- Generates per-stage stall codes (Pass/Hold/Bubb) for the PC and for the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Tracks an in-flight fetch that is squashed by a taken branch, and counts stall cycles for performance monitoring.

Parameters:
- MAX_MEM_BURST, 4: consecutive MEM grants allowed while IF is pending before IF is forced a grant; range 1..15.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  IF requests an instruction fetch; held until if_done
- mem_req  in  1  MEM stage requests a load/store; held until mem_done
- mctl_done  in  1  one-cycle pulse: the granted access completed
- grant_if  out  1  memory port owned by IF
- grant_mem  out  1  memory port owned by MEM
- if_done  out  1  fetch data valid this cycle (suppressed if discarded)
- mem_done  out  1  load/store completed this cycle
- id_stall_req  in  1  load-use hazard detected in ID
- ex_branch_taken  in  1  EX resolved a taken branch or jump; flush
- stall_pc  out  2  PC update code
- stall_if_id  out  2  if_id register code
- stall_id_ex  out  2  id_ex register code
- stall_ex_mem  out  2  ex_mem register code
- stall_mem_wb  out  2  mem_wb register code
- stall_cnt  out  CNT_W  cycles in which stall_pc == Hold; saturating

Behaviour:
- Stall codes: Pass = 2'b00, Hold = 2'b01, Bubb = 2'b10. Code 2'b11 is never driven.
- Reset (rst_n low, asynchronous):
  - Arbiter FSM goes to IDLE; grants 0; discard flag 0; burst counter 0; stall_cnt 0.
  - Combinational outputs follow the reset state: dones 0; all stall codes Pass.
- Arbiter FSM states and transitions:
  - IDLE: if mem_req and (burst_cnt < MAX_MEM_BURST or !if_req), go to SERVE_MEM. Else if if_req, go to SERVE_IF. Else stay in IDLE.
  - SERVE_MEM: grant_mem = 1. On mctl_done: mem_done = 1 (combinational, same cycle), go to IDLE. If if_req is pending, burst_cnt increments; otherwise it clears.
  - SERVE_IF: grant_if = 1. On mctl_done: if_done = !discard, clear discard, clear burst_cnt, go to IDLE.
  - Grants are registered: exactly one grant or none, and each grant is held constant for the whole transaction.
  - One idle cycle separates consecutive transactions. Minimum access latency is 1 cycle after grant.
- Discard flag:
  - Set when ex_branch_taken = 1 while in SERVE_IF and mctl_done = 0.
  - If ex_branch_taken and mctl_done coincide in SERVE_IF, if_done is forced to 0 that cycle and discard is not set.
- Stall generation (combinational, first matching rule wins):
  - mem_wait = mem_req & !mem_done; if_wait = if_req & !if_done.
  - 1. mem_wait: pc, if_id, id_ex, ex_mem = Hold; mem_wb = Bubb.
  - 2. ex_branch_taken: pc = Pass; if_id = Bubb; id_ex = Bubb; ex_mem = Pass; mem_wb = Pass.
  - 3. id_stall_req: pc = Hold; if_id = Hold; id_ex = Bubb; ex_mem = Pass; mem_wb = Pass.
  - 4. if_wait: pc = Hold; if_id = Bubb; others Pass.
  - 5. Otherwise all Pass.
  - A branch that arrives during rule 1 is not lost: EX is held, so ex_branch_taken stays asserted until rule 1 clears.
- stall_cnt: increments by 1 each cycle in which stall_pc == Hold; saturates at all-ones.
- Protocol violations (mctl_done in IDLE, both grants requested externally) are ignored; the FSM stays in its current state.

Decomposition:
- Shared package/defines file holds: `StallBus` width; `Pass`/`Hold`/`Bubb` codes; arbiter state encodings (IDLE = 0, SERVE_IF = 1, SERVE_MEM = 2).
- Natural sub-module: mem_port_arb (FSM, burst counter, discard flag, grants, dones).
- pipe_ctrl instantiates mem_port_arb and adds the stall-priority logic and stall_cnt.

Test Plan:
- Reset: rst_n low mid-SERVE_MEM -> grants 0 immediately (async); stall codes all Pass; stall_cnt 0.
- Contention: if_req = mem_req = 1 held, mctl_done 2 cycles after each grant -> first 4 grants go to MEM, 5th to IF; burst_cnt resets afterwards.
- Fetch wait: if_req = 1, mctl_done after 3 cycles -> stall_pc = Hold and stall_if_id = Bubb for 4 cycles; if_done pulses 1 cycle; stall_cnt = 4.
- Squash: branch in cycle 1 of SERVE_IF, mctl_done in cycle 3 -> if_id = Bubb and id_ex = Bubb in cycle 1; if_done stays 0 in cycle 3; discard clears.
- Load-use plus MEM wait: id_stall_req = 1 and mem_wait = 1 -> rule 1 codes (Hold×4, mem_wb Bubb). After mem_done, id_ex = Bubb with pc and if_id Hold.
- Coincident branch and mctl_done in SERVE_IF -> if_done = 0, discard stays 0, FSM returns to IDLE next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: stall codes, stall bus payload, arbiter states.
package pipe_ctrl_pkg;

  localparam int unsigned StallBus = 2;
  localparam int unsigned BurstW   = 4;

  typedef enum logic [StallBus-1:0] {
    PASS = 2'b00,
    HOLD = 2'b01,
    BUBB = 2'b10
  } stall_e;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SERVE_IF  = 2'd1,
    ARB_SERVE_MEM = 2'd2
  } arb_state_e;

  typedef struct packed {
    stall_e pc;
    stall_e if_id;
    stall_e id_ex;
    stall_e ex_mem;
    stall_e mem_wb;
  } stall_bus_t;

  function automatic stall_bus_t make_stall(stall_e pc, stall_e if_id, stall_e id_ex,
                                            stall_e ex_mem, stall_e mem_wb);
    stall_bus_t s;
    s.pc     = pc;
    s.if_id  = if_id;
    s.id_ex  = id_ex;
    s.ex_mem = ex_mem;
    s.mem_wb = mem_wb;
    return s;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-controller bus: memory-port handshake, hazard inputs and per-stage stall codes.
interface pipe_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic                  if_req;
  logic                  mem_req;
  logic                  mctl_done;
  logic                  id_stall_req;
  logic                  ex_branch_taken;
  logic                  grant_if;
  logic                  grant_mem;
  logic                  if_done;
  logic                  mem_done;
  logic [StallBus-1:0]   stall_pc;
  logic [StallBus-1:0]   stall_if_id;
  logic [StallBus-1:0]   stall_id_ex;
  logic [StallBus-1:0]   stall_ex_mem;
  logic [StallBus-1:0]   stall_mem_wb;
  logic [CNT_W-1:0]      stall_cnt;

  // Pipeline / memory side drives requests and consumes grants and stall codes.
  modport master (
    output if_req, mem_req, mctl_done, id_stall_req, ex_branch_taken,
    input  grant_if, grant_mem, if_done, mem_done,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, stall_cnt
  );

  modport slave (
    input  if_req, mem_req, mctl_done, id_stall_req, ex_branch_taken,
    output grant_if, grant_mem, if_done, mem_done,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, stall_cnt
  );

endinterface

// File: rtl/pipe_ctrl_mem_port_arb.sv
// Memory-port arbiter between IF and MEM: FSM, MEM burst limiter, squashed-fetch discard flag.
module pipe_ctrl_mem_port_arb
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MEM_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic mem_req,
  input  logic mctl_done,
  input  logic ex_branch_taken,
  output logic grant_if,
  output logic grant_mem,
  output logic if_done_c,
  output logic mem_done_c
);

  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_MEM_BURST);
  localparam logic [BurstW-1:0] BurstSat = '1;

  arb_state_e        state_q, state_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              discard_q, discard_d;

  // State, grants, burst counter and discard flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      burst_q   <= '0;
      discard_q <= 1'b0;
      grant_if  <= 1'b0;
      grant_mem <= 1'b0;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      discard_q <= discard_d;
      grant_if  <= (state_d == ARB_SERVE_IF);
      grant_mem <= (state_d == ARB_SERVE_MEM);
    end
  end

  // Next-state and completion decode.
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    discard_d  = discard_q;
    if_done_c  = 1'b0;
    mem_done_c = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Stray mctl_done here is a protocol violation and is ignored.
        if (mem_req && ((burst_q < BurstMax) || !if_req)) begin
          state_d = ARB_SERVE_MEM;
        end else if (if_req) begin
          state_d = ARB_SERVE_IF;
        end
      end
      ARB_SERVE_MEM: begin
        if (mctl_done) begin
          mem_done_c = 1'b1;
          state_d    = ARB_IDLE;
          if (!if_req) begin
            burst_d = '0;
          end else if (burst_q != BurstSat) begin
            burst_d = burst_q + BurstW'(1);
          end
        end
      end
      ARB_SERVE_IF: begin
        if (mctl_done) begin
          // A branch in the completion cycle squashes the fetch without arming discard.
          if_done_c = !discard_q && !ex_branch_taken;
          discard_d = 1'b0;
          burst_d   = '0;
          state_d   = ARB_IDLE;
        end else if (ex_branch_taken) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: memory-port arbitration, stall priority and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_MEM_BURST = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  logic             grant_if;
  logic             grant_mem;
  logic             if_done_c;
  logic             mem_done_c;
  logic             mem_wait;
  logic             if_wait;
  stall_bus_t       stall;
  logic [CNT_W-1:0] stall_cnt_q;

  pipe_ctrl_mem_port_arb #(
    .MAX_MEM_BURST (MAX_MEM_BURST)
  ) u_arb (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_req          (bus.if_req),
    .mem_req         (bus.mem_req),
    .mctl_done       (bus.mctl_done),
    .ex_branch_taken (bus.ex_branch_taken),
    .grant_if        (grant_if),
    .grant_mem       (grant_mem),
    .if_done_c       (if_done_c),
    .mem_done_c      (mem_done_c)
  );

  // Stall priority: memory wait, then branch flush, then load-use, then fetch wait.
  always_comb begin
    stall    = make_stall(PASS, PASS, PASS, PASS, PASS);
    mem_wait = bus.mem_req && !mem_done_c;
    if_wait  = bus.if_req && !if_done_c;
    if (!rst_n) begin
      stall = make_stall(PASS, PASS, PASS, PASS, PASS);
    end else if (mem_wait) begin
      stall = make_stall(HOLD, HOLD, HOLD, HOLD, BUBB);
    end else if (bus.ex_branch_taken) begin
      stall = make_stall(PASS, BUBB, BUBB, PASS, PASS);
    end else if (bus.id_stall_req) begin
      stall = make_stall(HOLD, HOLD, BUBB, PASS, PASS);
    end else if (if_wait) begin
      stall = make_stall(HOLD, BUBB, PASS, PASS, PASS);
    end
  end

  // Saturating count of PC-hold cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((stall.pc == HOLD) && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.grant_if     = grant_if;
  assign bus.grant_mem    = grant_mem;
  assign bus.if_done      = if_done_c;
  assign bus.mem_done     = mem_done_c;
  assign bus.stall_pc     = stall.pc;
  assign bus.stall_if_id  = stall.if_id;
  assign bus.stall_id_ex  = stall.id_ex;
  assign bus.stall_ex_mem = stall.ex_mem;
  assign bus.stall_mem_wb = stall.mem_wb;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule
